// File: rtl/otter_intc_pkg.sv
// Shared types and helpers for the OTTER interrupt controller.
// OTTER_INTC_LEVEL_EN (see otter_intc.sv) selects level-sensitive sources.
package otter_intc_pkg;

  localparam int NUM_SRC_DEF = 8;
  localparam int MAX_SRC     = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } intc_state_e;

  // Lowest set bit wins; callers truncate the result to their ID_W.
  function automatic logic [4:0] lowest_set(input logic [MAX_SRC-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/otter_intc_sync_edge.sv
// One-bit 2-flop synchroniser with rising-edge detect (or synced level when
// OTTER_INTC_LEVEL_EN is defined).
module intc_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic irq_in,
  output logic ev
);

  logic s1, s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= irq_in;
      s2 <= s1;
    end
  end

`ifdef OTTER_INTC_LEVEL_EN
  assign ev = s2;
`else
  logic dly;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) dly <= 1'b0;
    else     dly <= s2;
  end

  assign ev = s2 & ~dly;
`endif

endmodule

// File: rtl/otter_intc.sv
// Prioritising interrupt controller for the multicycle OTTER core.
// Define OTTER_INTC_LEVEL_EN for level-sensitive sources (default: edge).
module otter_intc
  import otter_intc_pkg::*;
#(
  parameter int NUM_SRC = NUM_SRC_DEF,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic               mie,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic               int_taken,
  input  logic               mret,
  output logic               intrpt_vld,
  output logic [ID_W-1:0]    irq_id,
  output logic [NUM_SRC-1:0] irq_mask,
  output logic [NUM_SRC-1:0] irq_pending,
  output logic               in_service
);

  intc_state_e        state_q, state_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [NUM_SRC-1:0] ev, pending, mask_q, eligible;
  logic [MAX_SRC-1:0] elig_ext;
  logic               vld_q, svc_q;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    intc_sync_edge u_sync (
      .clk    (clk),
      .rst    (rst),
      .irq_in (irq_src[i]),
      .ev     (ev[i])
    );
  end

`ifdef OTTER_INTC_LEVEL_EN
  assign pending = ev;
`else
  logic [NUM_SRC-1:0] pending_d;

  // A fresh edge in the same cycle as the claim wins over the clear.
  always_comb begin
    pending_d = pending;
    if (state_q == REQ && int_taken) pending_d[id_q] = 1'b0;
    pending_d = pending_d | ev;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pending_d;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          mask_q <= '0;
    else if (mask_we) mask_q <= mask_wdata;
  end

  assign eligible = pending & mask_q & {NUM_SRC{mie}};

  always_comb begin
    elig_ext = '0;
    elig_ext[NUM_SRC-1:0] = eligible;
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        if (|eligible) begin
          id_d    = ID_W'(lowest_set(elig_ext));
          state_d = REQ;
        end
      end
      REQ: begin
        if (int_taken)                              state_d = SVC;
        else if (!mie || !(pending[id_q] & mask_q[id_q])) state_d = IDLE;
      end
      SVC: begin
        if (mret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      vld_q   <= 1'b0;
      svc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      vld_q   <= (state_d == REQ);
      svc_q   <= (state_d == SVC);
    end
  end

  assign intrpt_vld  = vld_q;
  assign in_service  = svc_q;
  assign irq_id      = id_q;
  assign irq_mask    = mask_q;
  assign irq_pending = pending;

endmodule

// File: tb/tb_otter_intc.sv
// Directed, table-driven bench for otter_intc (NUM_SRC = 8).
module tb_otter_intc;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] irq_src;
  logic       mie, mask_we, int_taken, mret;
  logic [7:0] mask_wdata;
  logic       intrpt_vld, in_service;
  logic [2:0] irq_id;
  logic [7:0] irq_mask, irq_pending;

  int n_chk  = 0;
  int n_fail = 0;

  otter_intc #(.NUM_SRC(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .irq_src     (irq_src),
    .mie         (mie),
    .mask_we     (mask_we),
    .mask_wdata  (mask_wdata),
    .int_taken   (int_taken),
    .mret        (mret),
    .intrpt_vld  (intrpt_vld),
    .irq_id      (irq_id),
    .irq_mask    (irq_mask),
    .irq_pending (irq_pending),
    .in_service  (in_service)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] src;
    logic       mie;
    logic       mwe;
    logic [7:0] mwd;
    logic       take;
    logic       mret;
    logic       e_vld;
    logic [2:0] e_id;
    logic [7:0] e_pend;
    logic       e_svc;
    logic [7:0] e_mask;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [7:0] src, input logic mw, input logic [7:0] mwd,
                     input logic tk, input logic mr, input logic vld,
                     input logic [2:0] id, input logic [7:0] pend, input logic svc,
                     input logic [7:0] msk);
    vec_t v;
    v = '{src: src, mie: 1'b1, mwe: mw, mwd: mwd, take: tk, mret: mr,
          e_vld: vld, e_id: id, e_pend: pend, e_svc: svc, e_mask: msk};
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_all(input string nm, input logic vld, input logic [2:0] id,
                         input logic [7:0] pend, input logic svc, input logic [7:0] msk);
    chk({nm, ".vld"},  32'(intrpt_vld),  32'(vld));
    chk({nm, ".id"},   32'(irq_id),      32'(id));
    chk({nm, ".pend"}, 32'(irq_pending), 32'(pend));
    chk({nm, ".svc"},  32'(in_service),  32'(svc));
    chk({nm, ".mask"}, 32'(irq_mask),    32'(msk));
  endtask

  initial begin
    rst = 1'b1; irq_src = '0; mie = 1'b0; mask_we = 1'b0; mask_wdata = '0;
    int_taken = 1'b0; mret = 1'b0;
    @(negedge clk);
    step();
    chk_all("reset", 1'b0, 3'd0, 8'h00, 1'b0, 8'h00);
    rst = 1'b0;
    mie = 1'b1;

`ifdef OTTER_INTC_LEVEL_EN
    mask_we = 1'b1; mask_wdata = 8'hFF; step(); mask_we = 1'b0;
    irq_src = 8'h10; step(); step();
    chk("lvl.pend", 32'(irq_pending), 32'h10);
    step();
    chk("lvl.vld", 32'(intrpt_vld), 32'd1);
    chk("lvl.id", 32'(irq_id), 32'd4);
    int_taken = 1'b1; step(); int_taken = 1'b0;
    chk("lvl.svc", 32'(in_service), 32'd1);
    chk("lvl.pend_held", 32'(irq_pending), 32'h10);
    irq_src = 8'h00; step(); step();
    chk("lvl.pend_drop", 32'(irq_pending), 32'h00);
    mret = 1'b1; step(); mret = 1'b0;
    chk("lvl.svc_end", 32'(in_service), 32'd0);
    step();
    chk("lvl.no_rereq", 32'(intrpt_vld), 32'd0);
`else
    //   src  mwe mwd  tk mr  vld id pend  svc mask
    add(8'h00, 1, 8'hFF, 0, 0, 0, 0, 8'h00, 0, 8'hFF);
    add(8'h08, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'hFF);
    add(8'h08, 0, 8'h00, 0, 0, 0, 0, 8'h00, 0, 8'hFF);
    add(8'h00, 0, 8'h00, 0, 0, 0, 0, 8'h08, 0, 8'hFF);
    add(8'h00, 0, 8'h00, 0, 0, 1, 3, 8'h08, 0, 8'hFF);
    add(8'h00, 0, 8'h00, 1, 0, 0, 3, 8'h00, 1, 8'hFF);
    add(8'h00, 0, 8'h00, 0, 0, 0, 3, 8'h00, 1, 8'hFF);
    add(8'h00, 0, 8'h00, 0, 1, 0, 3, 8'h00, 0, 8'hFF);
    add(8'h00, 0, 8'h00, 0, 0, 0, 3, 8'h00, 0, 8'hFF);
    add(8'h24, 0, 8'h00, 0, 0, 0, 3, 8'h00, 0, 8'hFF);
    add(8'h24, 0, 8'h00, 0, 0, 0, 3, 8'h00, 0, 8'hFF);
    add(8'h24, 0, 8'h00, 0, 0, 0, 3, 8'h24, 0, 8'hFF);
    add(8'h24, 0, 8'h00, 0, 0, 1, 2, 8'h24, 0, 8'hFF);
    add(8'h00, 0, 8'h00, 1, 0, 0, 2, 8'h20, 1, 8'hFF);
    add(8'h00, 0, 8'h00, 0, 1, 0, 2, 8'h20, 0, 8'hFF);
    add(8'h00, 0, 8'h00, 0, 0, 1, 5, 8'h20, 0, 8'hFF);
    add(8'h00, 0, 8'h00, 1, 0, 0, 5, 8'h00, 1, 8'hFF);
    add(8'h00, 0, 8'h00, 0, 1, 0, 5, 8'h00, 0, 8'hFF);
    add(8'h00, 0, 8'h00, 1, 0, 0, 5, 8'h00, 0, 8'hFF);

    foreach (vecs[i]) begin
      irq_src = vecs[i].src; mie = vecs[i].mie; mask_we = vecs[i].mwe;
      mask_wdata = vecs[i].mwd; int_taken = vecs[i].take; mret = vecs[i].mret;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].e_vld, vecs[i].e_id, vecs[i].e_pend,
              vecs[i].e_svc, vecs[i].e_mask);
    end
    irq_src = '0; mask_we = 1'b0; int_taken = 1'b0; mret = 1'b0;

    // Masked source stays pending until unmasked.
    mask_we = 1'b1; mask_wdata = 8'h00; step(); mask_we = 1'b0;
    chk("mask.clear", 32'(irq_mask), 32'h00);
    irq_src = 8'h02; step(); step(); irq_src = 8'h00; step();
    chk("mask.pend", 32'(irq_pending), 32'h02);
    chk("mask.novld0", 32'(intrpt_vld), 32'd0);
    step(); step();
    chk("mask.novld1", 32'(intrpt_vld), 32'd0);
    mask_we = 1'b1; mask_wdata = 8'h02; step(); mask_we = 1'b0;
    step();
    chk("mask.vld", 32'(intrpt_vld), 32'd1);
    chk("mask.id", 32'(irq_id), 32'd1);

    // Dropping mie while requesting withdraws the request but keeps pending.
    mie = 1'b0; step();
    chk("mie.drop_vld", 32'(intrpt_vld), 32'd0);
    chk("mie.drop_pend", 32'(irq_pending), 32'h02);
    mie = 1'b1; step();
    chk("mie.rereq_vld", 32'(intrpt_vld), 32'd1);
    chk("mie.rereq_id", 32'(irq_id), 32'd1);
    int_taken = 1'b1; step(); int_taken = 1'b0;
    chk("mie.svc", 32'(in_service), 32'd1);
    chk("mie.pend_clr", 32'(irq_pending), 32'h00);

    // New edge during service waits for mret.
    mask_we = 1'b1; mask_wdata = 8'hFF; step(); mask_we = 1'b0;
    irq_src = 8'h01; step(); step(); irq_src = 8'h00; step();
    chk("svc.pend", 32'(irq_pending), 32'h01);
    chk("svc.novld", 32'(intrpt_vld), 32'd0);
    step();
    chk("svc.novld2", 32'(intrpt_vld), 32'd0);
    mret = 1'b1; step(); mret = 1'b0;
    chk("svc.idle", 32'(in_service), 32'd0);
    chk("svc.idle_vld", 32'(intrpt_vld), 32'd0);
    step();
    chk("svc.next_vld", 32'(intrpt_vld), 32'd1);
    chk("svc.next_id", 32'(irq_id), 32'd0);
    int_taken = 1'b1; step(); int_taken = 1'b0;
    irq_src = 8'h40; step(); step(); irq_src = 8'h00; step();
    chk("svc.pend40", 32'(irq_pending), 32'h40);
    chk("svc.in_svc", 32'(in_service), 32'd1);

    // Asynchronous reset mid-service clears everything before any edge.
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 1'b0, 3'd0, 8'h00, 1'b0, 8'h00);
    step();
    rst = 1'b0;
    step();
    chk_all("post_rst", 1'b0, 3'd0, 8'h00, 1'b0, 8'h00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
